// File: rtl/mul32_arbiter.sv
// mul32_arbiter: round-robin sharing of one sequential multiplier.
// Optional feature macro: MUL_ARB_ZERO_BYPASS_EN (zero operands skip it).
module mul32_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [N-1:0]      resp_upper,
  output logic [N-1:0]      resp_lower,
  output logic              mul_enable,
  output logic [N-1:0]      mul_multiplier,
  output logic [N-1:0]      mul_multiplicand,
  input  logic              mul_ready,
  input  logic [N-1:0]      mul_product_upper,
  input  logic [N-1:0]      mul_product_lower
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;

  logic           hi_any, lo_any;
  logic [IDW-1:0] hi_id, lo_id;
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [NREQ-1:0] gnt;
  logic [N-1:0]   gnt_a, gnt_b;
  logic           accept;
  logic           zero_op;

  // Winner: first valid at/after rr_ptr, else wrap to first valid.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !lo_any) begin
        lo_any = 1'b1;
        lo_id  = IDW'(i);
      end
      if (req_valid[i] && !hi_any &&
          (IDW'(i) >= rr_ptr_q)) begin
        hi_any = 1'b1;
        hi_id  = IDW'(i);
      end
    end
    gnt_any = hi_any | lo_any;
    gnt_id  = hi_any ? hi_id : lo_id;
  end

  // One-hot grant vector and operand mux for the winner.
  always_comb begin
    gnt   = '0;
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_any && (gnt_id == IDW'(i))) begin
        gnt[i] = 1'b1;
        gnt_a  = req_a[i*N +: N];
        gnt_b  = req_b[i*N +: N];
      end
    end
  end

  assign accept = (state_q == IDLE) && gnt_any;

  assign req_ready = ((state_q == IDLE) && !reset)
                   ? gnt : '0;

`ifdef MUL_ARB_ZERO_BYPASS_EN
  assign zero_op = (gnt_a == '0) || (gnt_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next state: accept in IDLE, wait product in RUN, drain in DONE.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d  = gnt_a;
          b_d  = gnt_b;
          id_d = gnt_id;
          if (gnt_id == IDW'(NREQ-1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = gnt_id + IDW'(1);
          end
          if (zero_op) begin
            hi_d    = '0;
            lo_d    = '0;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (mul_ready) begin
          hi_d    = mul_product_upper;
          lo_d    = mul_product_lower;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mul_enable       = (state_q == RUN);
  assign mul_multiplier   = a_q;
  assign mul_multiplicand = b_q;
  assign resp_valid       = (state_q == DONE);
  assign resp_id          = id_q;
  assign resp_upper       = hi_q;
  assign resp_lower       = lo_q;

endmodule

// File: tb/tb_mul32_arbiter.sv
// tb_mul32_arbiter: scoreboard bench with a behavioural multiplier.
// Zero-bypass expectations follow MUL_ARB_ZERO_BYPASS_EN.
module tb_mul32_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [N-1:0]      resp_upper;
  logic [N-1:0]      resp_lower;
  logic              mul_enable;
  logic [N-1:0]      mul_multiplier;
  logic [N-1:0]      mul_multiplicand;
  logic              mul_ready;
  logic [N-1:0]      mul_product_upper;
  logic [N-1:0]      mul_product_lower;

  mul32_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_id          (resp_id),
    .resp_upper       (resp_upper),
    .resp_lower       (resp_lower),
    .mul_enable       (mul_enable),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_ready        (mul_ready),
    .mul_product_upper(mul_product_upper),
    .mul_product_lower(mul_product_lower)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Behavioural sequential multiplier with programmable latency.
  int   lat  = 4;
  int   cnt;
  logic spur = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt               <= 0;
      mul_ready         <= 1'b0;
      mul_product_upper <= '0;
      mul_product_lower <= '0;
    end else if (spur) begin
      mul_ready <= 1'b1;
      {mul_product_upper, mul_product_lower}
        <= 64'hDEAD_BEEF_1234_5678;
    end else if (mul_enable) begin
      if (cnt >= lat) begin
        mul_ready <= 1'b1;
        {mul_product_upper, mul_product_lower}
          <= {32'b0, mul_multiplier} *
             {32'b0, mul_multiplicand};
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt       <= 0;
      mul_ready <= 1'b0;
    end
  end

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    p;
  } exp_t;

  exp_t sb[$];
  int   id_log[$];
  int   nresp  = 0;
  int   en_cnt = 0;

  // Scoreboard: push on accept, pop and compare on response.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (mul_enable) en_cnt++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = IDW'(i);
          e.p  = {32'b0, req_a[i*N +: N]} *
                 {32'b0, req_b[i*N +: N]};
          sb.push_back(e);
        end
      end
      if (resp_valid) chk("en_low_done", 64'(mul_enable), 0);
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_hi", 64'(resp_upper), 64'(e.p[63:32]));
          chk("resp_lo", 64'(resp_lower), 64'(e.p[31:0]));
        end
        id_log.push_back(int'(resp_id));
        nresp++;
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic [31:0] b, input logic v);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_valid[i]    = v;
  endtask

  // Wait for any grant; returns at posedge+1 after the accept edge.
  task automatic wait_grant(output logic [NREQ-1:0] g);
    g = '0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = req_ready;
        break;
      end
    end
    if (g == '0) chk("grant_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [31:0] a,
                      input logic [31:0] b);
    logic [NREQ-1:0] g;
    @(posedge clk);
    #1;
    set_req(i, a, b, 1'b1);
    wait_grant(g);
    chk("grant", 64'(g), 64'(1) << i);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_nresp(input int n);
    bool_wait: begin
      for (int k = 0; k < 2000; k++) begin
        @(posedge clk);
        #2;
        if (nresp >= n) disable bool_wait;
      end
      chk("resp_timeout", 64'(nresp), 64'(n));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 0);
    chk({tag, "_resp_id"}, 64'(resp_id), 0);
    chk({tag, "_resp_upper"}, 64'(resp_upper), 0);
    chk({tag, "_resp_lower"}, 64'(resp_lower), 0);
    chk({tag, "_mul_enable"}, 64'(mul_enable), 0);
    chk({tag, "_mul_a"}, 64'(mul_multiplier), 0);
    chk({tag, "_mul_b"}, 64'(mul_multiplicand), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

  initial begin
    int n0, base, e0;
    logic [NREQ-1:0] g;
    logic [N-1:0] h_hi, h_lo;
    logic [IDW-1:0] h_id;
    logic seen;

    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    @(posedge clk);
    #1 reset = 1'b0;

    // Single job 3 x 3 from requester 0.
    n0 = nresp;
    @(posedge clk);
    #1;
    set_req(0, 32'd3, 32'd3, 1'b1);
    wait_grant(g);
    req_valid[0] = 1'b0;
    chk("single_grant", 64'(g), 1);
    chk("single_en", 64'(mul_enable), 1);
    chk("single_mul_a", 64'(mul_multiplier), 3);
    chk("single_mul_b", 64'(mul_multiplicand), 3);
    wait_nresp(n0 + 1);

    // Full-width product from requester 1.
    n0 = nresp;
    send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_nresp(n0 + 1);

    // Spurious mul_ready while idle must be ignored.
    n0 = nresp;
    @(posedge clk);
    #1 spur = 1'b1;
    @(posedge clk);
    #1 spur = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("spur_resp_valid", 64'(resp_valid), 0);
    end
    chk("spur_nresp", 64'(nresp), 64'(n0));

    // Fairness: both requesters valid continuously.
    pulse_reset();
    base = id_log.size();
    n0   = nresp;
    @(posedge clk);
    #1;
    set_req(0, 32'd2, 32'd5, 1'b1);
    set_req(1, 32'd7, 32'd6, 1'b1);
    wait_nresp(n0 + 6);
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      if (id_log.size() > base + k) begin
        chk("fair_id", 64'(id_log[base+k]), 64'(k % 2));
      end else begin
        chk("fair_missing", 0, 1);
      end
    end

    // Backpressure in DONE with both requesters waiting.
    n0 = nresp;
    base = id_log.size();
    @(posedge clk);
    #1 resp_ready = 1'b0;
    send(0, 32'd11, 32'd13);
    set_req(1, 32'd8, 32'd9, 1'b1);
    set_req(0, 32'd5, 32'd5, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_resp_valid", 64'(seen), 1);
    h_hi = resp_upper;
    h_lo = resp_lower;
    h_id = resp_id;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(resp_valid), 1);
      chk("bp_hold_hi", 64'(resp_upper), 64'(h_hi));
      chk("bp_hold_lo", 64'(resp_lower), 64'(h_lo));
      chk("bp_hold_id", 64'(resp_id), 64'(h_id));
      chk("bp_req_ready", 64'(req_ready), 0);
      chk("bp_mul_en", 64'(mul_enable), 0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_grant(g);
    chk("bp_grant_r1", 64'(g), 2);
    req_valid[1] = 1'b0;
    wait_grant(g);
    chk("bp_grant_r0", 64'(g), 1);
    req_valid[0] = 1'b0;
    wait_nresp(n0 + 3);
    if (id_log.size() >= base + 3) begin
      chk("bp_order0", 64'(id_log[base]), 0);
      chk("bp_order1", 64'(id_log[base+1]), 1);
      chk("bp_order2", 64'(id_log[base+2]), 0);
    end else begin
      chk("bp_order_missing", 0, 1);
    end

    // Reset 10 cycles into a long job.
    lat = 30;
    send(1, 32'd100, 32'd200);
    send(0, 32'd100, 32'd200);
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_reset_outs("midrst");
    n0 = nresp;
    @(posedge clk);
    #1 reset = 1'b0;
    lat  = 4;
    base = id_log.size();
    set_req(0, 32'd4, 32'd4, 1'b1);
    set_req(1, 32'd9, 32'd9, 1'b1);
    wait_grant(g);
    chk("midrst_grant", 64'(g), 1);
    req_valid = '0;
    wait_nresp(n0 + 1);
    if (id_log.size() > base) begin
      chk("midrst_id", 64'(id_log[base]), 0);
    end else begin
      chk("midrst_missing", 0, 1);
    end

    // Zero operand job 0 x 7.
    n0 = nresp;
    e0 = en_cnt;
    @(posedge clk);
    #1;
    set_req(0, 32'd0, 32'd7, 1'b1);
    wait_grant(g);
    req_valid[0] = 1'b0;
    chk("zero_grant", 64'(g), 1);
`ifdef MUL_ARB_ZERO_BYPASS_EN
    chk("zero_bypass_valid", 64'(resp_valid), 1);
    chk("zero_bypass_en", 64'(mul_enable), 0);
`else
    chk("zero_run_en", 64'(mul_enable), 1);
`endif
    wait_nresp(n0 + 1);
`ifdef MUL_ARB_ZERO_BYPASS_EN
    chk("zero_en_cycles", 64'(en_cnt - e0), 0);
`else
    chk("zero_en_used", 64'(en_cnt > e0), 1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
